alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares one instance of the team's 3-bit-opcode 32-bit ALU between NREQ requesters.
- Requesters present operands and an opcode over a valid/ready request channel. The block grants one round-robin, latches operands, runs the ALU, and returns res/zero over a valid/ready response channel to the granted requester.
- Sits between multi-cycle datapath clients (e.g. address calc, compare unit) and the single ALU.

Parameters:
- NREQ, 2, number of requesters (1..4); index i occupies bits [i*W +: W] of packed buses
- W, 32, data width; must stay 32 to match the ALU

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous reset, active low
- req_valid  input  NREQ  request i valid
- req_ready  output  NREQ  request i accepted this cycle (one-hot or zero)
- req_a  input  NREQ*W  operand A per requester
- req_b  input  NREQ*W  operand B per requester
- req_op  input  NREQ*3  ALU opcode per requester
- rsp_valid  output  NREQ  response i valid (one-hot or zero)
- rsp_ready  input  NREQ  requester i takes response
- rsp_res  output  W  result, shared by all requesters; meaningful only where rsp_valid is set
- rsp_zero  output  1  zero flag of rsp_res
- busy  output  1  high in any state except IDLE
- grant_id  output  2  index of current or last granted requester

Behaviour:
- States: IDLE, EXEC, RESP; 2-bit registered state.
- Reset (rstn=0 at a clk edge): state=IDLE, rr pointer=0, grant_id=0, operand/op/result registers=0, rsp_valid=0, rsp_zero=0, busy=0. Reset mid-EXEC or mid-RESP discards the operation; no response is issued.
- IDLE:
  - g = first i with req_valid[i]=1, searching from the pointer upward with wrap.
  - req_ready[g]=1, combinational, this cycle only. The transfer occurs in this cycle.
  - Latch req_a/b/op of g and grant_id=g, then go to EXEC.
  - With no valid request, stay in IDLE and keep req_ready=0.
- EXEC:
  - The ALU is driven only from latched registers.
  - Register res and zero, then go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid[grant_id]=1; rsp_res and rsp_zero stay stable.
  - When rsp_ready[grant_id]=1: pointer = (grant_id+1) mod NREQ, go to IDLE.
  - rsp_ready on other bits is ignored.
- Latency and throughput:
  - Request accepted at cycle T gives rsp_valid at T+2.
  - Minimum issue interval is 3 cycles, with zero back-pressure.
- Req_ready is never asserted outside IDLE. A requester may drop req_valid before it is granted; this is legal and nothing is recorded.
- Simultaneous requests: only the pointer-priority winner is served. The others wait, and each is guaranteed service within NREQ grants.
- Opcodes follow the ALU:
  - 000 and, 001 or, 010 add, 011 xor, 110 sub (wrap mod 2^32)
  - 101 srl by B[4:0]
  - 111 signed slt
  - 100 gives res=0, zero=1; no error flag
- No overflow reporting.
- With NREQ=1, the pointer stays at 0.

Decomposition:
- Shared package alu_pkg:
  - opcode constants (OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SRL, OP_SUB, OP_SLT)
  - state encoding constants S_IDLE/S_EXEC/S_RESP
- Sub-module rr_pick:
  - combinational round-robin picker
  - inputs: req vector, pointer
  - outputs: grant index, any
- The existing ALU is instantiated once, unmodified.

Test Plan:
- Single request, requester 0: a=7, b=5, op=010 at T. Required: req_ready[0] at T, rsp_valid[0] at T+2, res=0x0000000C, zero=0, busy high T+1..accept.
- Both requesters valid from reset (r0: sub 5-5, r1: slt 0xFFFFFFFF,1). Required: r0 is served first with res=0, zero=1. r1 is served next with res=1. Third round, both valid again: r0 first again, because the pointer wrapped to 0.
- Back-pressure: r1 srl a=0x80000000, b=0x21, rsp_ready held 0 for 5 cycles. Required: rsp_valid[1] and res=0x40000000 stable throughout. req_ready stays 0 even with r0 valid; r0 is granted the cycle after the accept.
- rstn low for one cycle while in EXEC. Required: next cycle IDLE, busy=0, rsp_valid=0, no response ever issued for the dropped op.
- Invalid op 100 from r0, a=0xFFFF, b=1. Required: res=0, zero=1, normal handshake timing.
- Requester raises then drops req_valid during another requester's RESP. Required: no grant to it, and the pointer advances only on response accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its request sequencer: opcodes and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOP = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Team 3-bit-opcode combinational ALU; opcode 100 yields zero with no error flag.
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [2:0]   i_op,
    output logic [W-1:0] o_res,
    output logic         o_zero
);

    logic signed [W-1:0] w_sa;
    logic signed [W-1:0] w_sb;

    assign w_sa = i_a;
    assign w_sb = i_b;

    // Opcode decode; shift amount uses only the low five bits of B.
    always_comb begin
        o_res = '0;
        case (i_op)
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_ADD:  o_res = i_a + i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_SRL:  o_res = i_a >> i_b[4:0];
            OP_SUB:  o_res = i_a - i_b;
            OP_SLT:  o_res = {{(W-1){1'b0}}, (w_sa < w_sb)};
            default: o_res = '0;
        endcase
    end

    assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first requester at or above the pointer, with wrap.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [1:0]      o_gnt,
    output logic            o_any
);

    int w_idx;

    // Scan from farthest to nearest so the nearest valid requester is written last and wins.
    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (i == w_idx && i_req[i]) begin
                    o_gnt = 2'(i);
                    o_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one ALU among NREQ requesters over valid/ready channels.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [NREQ-1:0] rsp_valid,
    input  logic [NREQ-1:0] rsp_ready,
    output logic [W-1:0]    rsp_res,
    output logic            rsp_zero,
    output logic            busy,
    output logic [1:0]      grant_id
);

    localparam logic [1:0] LAST = 2'(NREQ - 1);

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [1:0]      r_gid;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;
    logic [W-1:0]    r_res;
    logic            r_zero;
    logic [NREQ-1:0] r_rsp_valid;
    logic            r_busy;

    logic [1:0]      w_gnt;
    logic            w_any;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [2:0]      w_sel_op;
    logic [W-1:0]    w_alu_res;
    logic            w_alu_zero;
    logic [NREQ-1:0] w_gid_oh;
    logic            w_rsp_take;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_any (w_any)
    );

    // ALU sees only latched operands, so requesters may change inputs after the accept.
    alu #(.W(W)) u_alu (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_op   (r_op),
        .o_res  (w_alu_res),
        .o_zero (w_alu_zero)
    );

    // Route the picked requester's operands toward the latch registers.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == 2'(i)) begin
                w_sel_a  = req_a[i*W +: W];
                w_sel_b  = req_b[i*W +: W];
                w_sel_op = req_op[i*3 +: 3];
            end
        end
    end

    assign w_gid_oh   = NREQ'(1) << r_gid;
    assign w_rsp_take = |(rsp_ready & w_gid_oh);
    assign req_ready  = (r_state == S_IDLE && w_any) ? (NREQ'(1) << w_gnt) : '0;

    // Sequencer FSM: accept in IDLE, compute in EXEC, hold the response in RESP until taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_res       <= '0;
            r_zero      <= 1'b0;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_gid   <= w_gnt;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res       <= w_alu_res;
                    r_zero      <= w_alu_zero;
                    r_rsp_valid <= w_gid_oh;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_ptr       <= (r_gid == LAST) ? 2'd0 : 2'(r_gid + 2'd1);
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_res;
    assign rsp_zero  = r_zero;
    assign busy      = r_busy;
    assign grant_id  = r_gid;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a transaction-level reference model.
module tb_alu_share_ctrl;

    localparam int NREQ = 2;
    localparam int W    = 32;

    logic            clk;
    logic            rstn;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] req_ready;
    logic [31:0]     A [NREQ];
    logic [31:0]     B [NREQ];
    logic [2:0]      OP [NREQ];
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ-1:0] rsp_valid;
    logic [NREQ-1:0] rsp_ready;
    logic [W-1:0]    rsp_res;
    logic            rsp_zero;
    logic            busy;
    logic [1:0]      grant_id;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    int waited;

    assign req_a  = {A[1], A[0]};
    assign req_b  = {B[1], B[0]};
    assign req_op = {OP[1], OP[0]};

    alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (v),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected ALU result straight from the opcode table.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            3'b011:  return a ^ b;
            3'b101:  return a / (32'd1 << (b % 32));
            3'b110:  return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Expected winner: first valid requester counting up from the pointer.
    function automatic int pick(input logic [NREQ-1:0] vec, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (vec[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        v         = '0;
        rsp_ready = '0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
        mptr = 0;
    endtask

    // One full transaction from the current request set; hold = cycles of response back-pressure.
    task automatic serve(input int hold, input bit glitch, output int wt);
        int g;
        logic [31:0] er;
        logic [31:0] oh;
        wt = 0;
        while (req_ready == '0 && wt < 16) begin
            tick();
            wt++;
        end
        g  = pick(v, mptr);
        oh = 32'(1) << g;
        chk("accept req_ready", 32'(req_ready), oh);
        chk("accept busy", 32'(busy), 32'd0);
        if (req_ready == '0) return;
        er = ref_res(OP[g], A[g], B[g]);
        tick();
        v[g] = 1'b0;
        #1;
        chk("exec busy", 32'(busy), 32'd1);
        chk("exec rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec req_ready", 32'(req_ready), 32'd0);
        chk("exec grant_id", 32'(grant_id), 32'(g));
        tick();
        chk("resp rsp_valid", 32'(rsp_valid), oh);
        chk("resp rsp_res", rsp_res, er);
        chk("resp rsp_zero", 32'(rsp_zero), 32'(er == 32'd0));
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 2'b11 & ~2'(oh);
            if (glitch) v[1-g] = (h == 1);
            #1;
            chk("hold rsp_valid", 32'(rsp_valid), oh);
            chk("hold rsp_res", rsp_res, er);
            chk("hold req_ready", 32'(req_ready), 32'd0);
            chk("hold busy", 32'(busy), 32'd1);
            tick();
        end
        if (glitch) v[1-g] = 1'b0;
        rsp_ready = 2'(oh);
        #1;
        chk("take rsp_valid", 32'(rsp_valid), oh);
        tick();
        rsp_ready = '0;
        #1;
        chk("post busy", 32'(busy), 32'd0);
        chk("post rsp_valid", 32'(rsp_valid), 32'd0);
        mptr = (g + 1) % NREQ;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            A[i] = '0; B[i] = '0; OP[i] = '0;
        end
        do_reset();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset rsp_res", rsp_res, 32'd0);
        chk("reset rsp_zero", 32'(rsp_zero), 32'd0);

        // Single add from requester 0
        A[0] = 32'd7; B[0] = 32'd5; OP[0] = 3'b010; v = 2'b01; #1;
        serve(0, 1'b0, waited);
        chk("add latency wait", 32'(waited), 32'd0);

        // Both valid from reset; pointer order r0, r1, then r0 again
        do_reset();
        A[0] = 32'd5; B[0] = 32'd5; OP[0] = 3'b110;
        A[1] = 32'hFFFF_FFFF; B[1] = 32'd1; OP[1] = 3'b111;
        v = 2'b11; #1;
        serve(0, 1'b0, waited);
        chk("round1 rsp_zero sub", 32'(rsp_zero), 32'd1);
        serve(0, 1'b0, waited);
        chk("round2 res slt", rsp_res, 32'd1);
        v = 2'b11; #1;
        chk("round3 r0 first", 32'(req_ready), 32'b01);
        serve(1, 1'b0, waited);

        // Back-pressure on r1 while r0 waits
        A[1] = 32'h8000_0000; B[1] = 32'h21; OP[1] = 3'b101;
        A[0] = 32'h1234; B[0] = 32'h00FF; OP[0] = 3'b000;
        v = 2'b11; #1;
        serve(5, 1'b0, waited);
        chk("srl result", rsp_res, 32'h4000_0000);
        serve(0, 1'b0, waited);
        chk("r0 granted right after", 32'(waited), 32'd0);

        // Opcode 100 yields zero
        A[0] = 32'h0000_FFFF; B[0] = 32'd1; OP[0] = 3'b100; v = 2'b01; #1;
        serve(2, 1'b0, waited);
        chk("op100 res", rsp_res, 32'd0);
        chk("op100 zero", 32'(rsp_zero), 32'd1);

        // Reset while in EXEC drops the operation
        do_reset();
        A[1] = 32'd1; B[1] = 32'd2; OP[1] = 3'b010; v = 2'b10; #1;
        chk("rx accept", 32'(req_ready), 32'b10);
        tick();
        v = '0; #1;
        chk("rx exec busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1; #1;
        chk("rx busy", 32'(busy), 32'd0);
        chk("rx rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rx grant_id", 32'(grant_id), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rx no response", 32'(rsp_valid), 32'd0);
        end

        // r1 pulses req_valid during r0's response; no grant, pointer moves only on accept
        A[0] = 32'd3; B[0] = 32'd9; OP[0] = 3'b011; v = 2'b01; #1;
        serve(3, 1'b1, waited);
        chk("glitch idle ready", 32'(req_ready), 32'd0);
        tick();
        chk("glitch still idle", 32'(busy), 32'd0);
        A[1] = 32'd10; B[1] = 32'd4; OP[1] = 3'b001; v = 2'b11; #1;
        chk("pointer at r1", 32'(req_ready), 32'b10);
        serve(0, 1'b0, waited);
        serve(0, 1'b0, waited);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                A[i]  = $urandom;
                B[i]  = ($urandom_range(0, 4) == 0) ? A[i] : $urandom;
                OP[i] = 3'($urandom_range(0, 7));
            end
            v = 2'($urandom_range(1, 3)); #1;
            serve($urandom_range(0, 3), 1'b0, waited);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
